// File: rtl/tile_map_scheduler_pkg.sv
// Shared types and geometry for the tile-map drawing path.
package tile_pkg;
  localparam int unsigned MAP_COLS  = 40;
  localparam int unsigned MAP_ROWS  = 30;
  localparam int unsigned MAP_DEPTH = MAP_COLS * MAP_ROWS;
  localparam int unsigned TILE_W    = 3;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned ADDR_W    = 11;

  typedef logic [TILE_W-1:0] tile_id_t;
  typedef logic [ADDR_W-1:0] map_addr_t;

  localparam tile_id_t CLEAR_TILE = '0;

  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic map_addr_t cell_addr(input logic [4:0] row, input logic [5:0] col);
    return map_addr_t'(row) * map_addr_t'(MAP_COLS) + map_addr_t'(col);
  endfunction
endpackage

// File: rtl/tile_map_scheduler_if.sv
// Host write handshake and clear-sweep control for the tile-map scheduler.
interface tile_map_scheduler_if;
  import tile_pkg::*;

  logic      host_req;
  map_addr_t host_addr;
  tile_id_t  host_tile;
  logic      host_ack;
  logic      clear_start;
  logic      busy;
  logic      clear_done;

  modport master (
    output host_req, host_addr, host_tile, clear_start,
    input  host_ack, busy, clear_done
  );

  modport slave (
    input  host_req, host_addr, host_tile, clear_start,
    output host_ack, busy, clear_done
  );
endinterface

// File: rtl/tile_map_scheduler_ram.sv
// 1200x3 single-port tile map, synchronous read and write (block RAM style).
module tile_map_ram
  import tile_pkg::*;
(
  input  logic      vga_clk,
  input  logic      we,
  input  map_addr_t addr,
  input  tile_id_t  wdata,
  output tile_id_t  q
);
  tile_id_t mem [MAP_DEPTH];

  always_ff @(posedge vga_clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end
endmodule

// File: rtl/tile_map_scheduler.sv
// Per-pixel tile lookup pipeline sharing one map port with host writes and a clear sweep.
module tile_map_scheduler
  import tile_pkg::*;
(
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  tile_map_scheduler_if.slave   host,
  output logic [10:0]           rom_address,
  input  logic [IDX_W-1:0]      rom_q,
  output logic [IDX_W-1:0]      pix_index,
  output logic                  pix_active
);
  state_t    state;
  map_addr_t clr_cnt;
  map_addr_t map_addr;
  logic      map_we;
  tile_id_t  map_wdata;
  tile_id_t  tile_id;
  logic [3:0] px_q, py_q;
  logic      blank_d1, blank_d2;
  logic      host_take, clear_take;
  logic      unused_draw_y9;

  always_comb unused_draw_y9 = DrawY[9];

  // Port arbitration. A host request is not re-taken during its own ack
  // cycle, since the host only releases req after it has seen ack.
  always_comb begin
    host_take  = !blank && (state == IDLE) && host.host_req && !host.host_ack
                 && !host.clear_start;
    clear_take = !blank && (state == CLEAR);
    map_addr   = '0;
    map_we     = 1'b0;
    map_wdata  = CLEAR_TILE;
    if (blank) begin
      map_addr = cell_addr(DrawY[8:4], DrawX[9:4]);
    end else if (clear_take) begin
      map_addr = clr_cnt;
      map_we   = 1'b1;
    end else if (host_take) begin
      map_addr  = host.host_addr;
      map_we    = host.host_addr < map_addr_t'(MAP_DEPTH);
      map_wdata = host.host_tile;
    end
  end

  tile_map_ram u_map (
    .vga_clk (vga_clk),
    .we      (map_we),
    .addr    (map_addr),
    .wdata   (map_wdata),
    .q       (tile_id)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state           <= IDLE;
      clr_cnt         <= '0;
      host.busy       <= 1'b0;
      host.clear_done <= 1'b0;
      host.host_ack   <= 1'b0;
    end else begin
      host.host_ack   <= host_take;
      host.clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.clear_start) begin
            state     <= CLEAR;
            host.busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_take) begin
            if (clr_cnt == map_addr_t'(MAP_DEPTH - 1)) begin
              state           <= IDLE;
              host.busy       <= 1'b0;
              host.clear_done <= 1'b1;
              clr_cnt         <= '0;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    px_q <= DrawX[3:0];
    py_q <= DrawY[3:0];
  end

  always_comb rom_address = {tile_id, py_q, px_q};

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_d1   <= 1'b0;
      blank_d2   <= 1'b0;
      pix_index  <= '0;
      pix_active <= 1'b0;
    end else begin
      blank_d1   <= blank;
      blank_d2   <= blank_d1;
      pix_active <= blank_d2;
      pix_index  <= blank_d2 ? rom_q : '0;
    end
  end
endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed bench for tile_map_scheduler: vector table plus handshake/sweep sequences.
`timescale 1ns/1ps
module tb_tile_map_scheduler;
  import tile_pkg::*;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [10:0] rom_address;
  logic [5:0]  rom_q = '0;
  logic [5:0]  pix_index;
  logic        pix_active;

  int errors = 0;
  int checks = 0;

  tile_map_scheduler_if hif();

  tile_map_scheduler dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .host        (hif),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_index   (pix_index),
    .pix_active  (pix_active)
  );

  always #5 vga_clk = ~vga_clk;

  // Tile ROM model: data = low 6 address bits, one-cycle synchronous read.
  always @(posedge vga_clk) rom_q <= rom_address[5:0];

  typedef struct {
    int   x;
    int   y;
    logic b;
    logic chk_rom;
    int   exp_rom;
    int   exp_pix;
    int   exp_act;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic read_cell(input int a, output int t);
    DrawX = 10'((a % 40) * 16);
    DrawY = 10'((a / 40) * 16);
    blank = 1'b1;
    tick();
    t = int'(rom_address[10:8]);
    blank = 1'b0;
  endtask

  task automatic host_write(input int a, input int t, output int acked);
    hif.host_req  = 1'b1;
    hif.host_addr = 11'(a);
    hif.host_tile = 3'(t);
    acked = 0;
    for (int i = 0; i < 3000 && acked == 0; i++) begin
      tick();
      if (hif.host_ack) acked = 1;
    end
    hif.host_req = 1'b0;
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, acked, bad, acks, busy_cycles, zero_cycles, cnt_at_done, dones;

    vecs[0] = '{16,  16,  1'b1, 1'b1, 'h500, 'h00, 1};
    vecs[1] = '{19,  18,  1'b1, 1'b1, 'h523, 'h23, 1};
    vecs[2] = '{117, 89,  1'b1, 1'b1, 'h695, 'h15, 1};
    vecs[3] = '{31,  31,  1'b1, 1'b1, 'h5FF, 'h3F, 1};
    vecs[4] = '{5,   10,  1'b1, 1'b1, 'h0A5, 'h25, 1};
    vecs[5] = '{639, 479, 1'b1, 1'b1, 'h0FF, 'h3F, 1};
    vecs[6] = '{19,  18,  1'b0, 1'b0, 0,     'h00, 0};

    reset = 1'b1; blank = 1'b0; DrawX = '0; DrawY = '0;
    hif.host_req = 1'b0; hif.host_addr = '0; hif.host_tile = '0; hif.clear_start = 1'b0;
    tick(); tick();
    check("reset_host_ack",   int'(hif.host_ack),   0);
    check("reset_busy",       int'(hif.busy),       0);
    check("reset_clear_done", int'(hif.clear_done), 0);
    check("reset_pix_index",  int'(pix_index),      0);
    check("reset_pix_active", int'(pix_active),     0);
    reset = 1'b0;
    tick();

    host_write(0, 7, acked);    check("prefill_ack_0", acked, 1);
    host_write(600, 7, acked);  check("prefill_ack_600", acked, 1);
    host_write(1199, 7, acked); check("prefill_ack_1199", acked, 1);
    read_cell(600, t);          check("prefill_read_600", t, 7);

    // Clear sweep with a simultaneous host request: the clear wins.
    hif.host_req = 1'b1; hif.host_addr = 11'd41; hif.host_tile = 3'd5;
    hif.clear_start = 1'b1; blank = 1'b0;
    tick();
    hif.clear_start = 1'b0;
    busy_cycles = 0; acks = 0;
    for (int i = 0; i < 1300 && hif.busy; i++) begin
      busy_cycles++;
      if (hif.host_ack) acks++;
      tick();
    end
    check("sweep_busy_cycles", busy_cycles, 1200);
    check("sweep_ack_while_busy", acks, 0);
    check("sweep_clear_done", int'(hif.clear_done), 1);
    tick();
    check("sweep_clear_done_pulse", int'(hif.clear_done), 0);
    check("sweep_host_ack_after", int'(hif.host_ack), 1);
    hif.host_req = 1'b0;
    tick();

    bad = 0;
    for (int a = 0; a < 1200; a++) begin
      read_cell(a, t);
      if (t != ((a == 41) ? 5 : 0)) bad++;
    end
    check("map_after_clear_bad_cells", bad, 0);

    // Host request held across active video.
    DrawX = '0; DrawY = '0; blank = 1'b1;
    hif.host_req = 1'b1; hif.host_addr = 11'd207; hif.host_tile = 3'd6;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hif.host_ack) acks++;
    end
    check("ack_during_video", acks, 0);
    blank = 1'b0;
    tick();
    check("ack_after_blank_falls", int'(hif.host_ack), 1);
    hif.host_req = 1'b0;
    tick();
    check("ack_single_pulse", int'(hif.host_ack), 0);
    read_cell(207, t);
    check("readback_207", t, 6);

    foreach (vecs[k]) begin
      DrawX = 10'(vecs[k].x); DrawY = 10'(vecs[k].y); blank = vecs[k].b;
      tick();
      if (vecs[k].chk_rom) check($sformatf("vec%0d_rom_address", k), int'(rom_address), vecs[k].exp_rom);
      tick(); tick();
      check($sformatf("vec%0d_pix_index", k), int'(pix_index), vecs[k].exp_pix);
      check($sformatf("vec%0d_pix_active", k), int'(pix_active), vecs[k].exp_act);
    end

    // Back-to-back pixels with blank falling on the third.
    blank = 1'b0; tick(); tick(); tick();
    DrawX = 10'd19; DrawY = 10'd18; blank = 1'b1;
    tick();
    check("stream_rom_p0", int'(rom_address), 'h523);
    DrawX = 10'd31; DrawY = 10'd31; blank = 1'b1;
    tick();
    check("stream_rom_p1", int'(rom_address), 'h5FF);
    check("stream_act_before", int'(pix_active), 0);
    DrawX = 10'd16; DrawY = 10'd16; blank = 1'b0;
    tick();
    check("stream_pix_p0", int'(pix_index), 'h23);
    check("stream_act_p0", int'(pix_active), 1);
    tick();
    check("stream_pix_p1", int'(pix_index), 'h3F);
    tick();
    check("stream_pix_p2", int'(pix_index), 0);
    check("stream_act_p2", int'(pix_active), 0);

    // Clear sweep interleaved with active video every 8 cycles.
    DrawX = '0; DrawY = '0; blank = 1'b0;
    hif.clear_start = 1'b1;
    tick();
    hif.clear_start = 1'b0;
    zero_cycles = 0; cnt_at_done = -1;
    for (int i = 0; i < 3000; i++) begin
      blank = ((i / 8) % 2) == 1;
      if (!blank) zero_cycles++;
      tick();
      if (hif.clear_done) begin
        cnt_at_done = zero_cycles;
        break;
      end
    end
    blank = 1'b0;
    check("interleaved_blank0_cycles", cnt_at_done, 1200);
    read_cell(41, t);
    check("interleaved_cell41_cleared", t, 0);

    host_write(1500, 7, acked);
    check("oob_ack", acked, 1);
    read_cell(300, t); check("oob_cell300", t, 0);
    read_cell(476, t); check("oob_cell476", t, 0);

    // Reset part-way through a sweep.
    hif.clear_start = 1'b1;
    tick();
    hif.clear_start = 1'b0;
    for (int i = 0; i < 600; i++) tick();
    check("midsweep_busy", int'(hif.busy), 1);
    reset = 1'b1;
    tick();
    check("midsweep_reset_busy", int'(hif.busy), 0);
    check("midsweep_reset_done", int'(hif.clear_done), 0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (hif.clear_done || hif.busy) dones++;
    end
    check("midsweep_no_done_after", dones, 0);

    // Reset during a host handshake.
    hif.host_req = 1'b1; hif.host_addr = 11'd10; hif.host_tile = 3'd3;
    reset = 1'b1;
    tick();
    check("reset_handshake_ack", int'(hif.host_ack), 0);
    hif.host_req = 1'b0; reset = 1'b0;
    tick();
    check("reset_handshake_ack_after", int'(hif.host_ack), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
